// File: rtl/yarp_pkg.sv
// Shared types and constants for the yarp fetch sequencer.
package yarp_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD,
    FETCH_DROP
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  // Clears the byte-offset bits so a PC always lands on an instruction boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/yarp_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and memory.
// Signal suffixes are named from the fetch sequencer's point of view.
interface yarp_fetch_ctrl_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/yarp_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps at most one request in flight,
// holds the returned instruction for decode and applies branch/jump redirects,
// dropping any response made stale by a redirect.
// Optional feature macro: YARP_FETCH_MISALIGN_EN (misaligned redirects park the
// sequencer in IDLE and raise a sticky misalign_o). Without it, redirect targets
// are word-aligned on load and misalign_o is tied low.
module yarp_fetch_ctrl
  import yarp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  yarp_fetch_ctrl_if.master imem,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [31:0]       instr_pc_o,
  input  logic              instr_ready_i,
  input  logic              branch_taken_i,
  input  logic              jump_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              misalign_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instrPc_q, instrPc_d;
  logic         req_q;
  logic         valid_q;
  logic         redirect;
  logic [31:0]  redirectPc;

  assign redirect = branch_taken_i | jump_i;

`ifdef YARP_FETCH_MISALIGN_EN
  logic misalign_q, misalign_d;
  logic misalignHit;

  assign misalignHit = redirect && (redirect_pc_i[1:0] != 2'b00);
  assign redirectPc  = misalignHit ? pc_q : redirect_pc_i;
  assign misalign_d  = misalign_q | misalignHit;
  assign misalign_o  = misalign_q;

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  logic unused_redirectLsbs;

  assign unused_redirectLsbs = ^redirect_pc_i[1:0];
  assign redirectPc          = align_pc(redirect_pc_i);
  assign misalign_o          = 1'b0;
`endif

  // Next-state and datapath decisions; a redirect outranks every other event.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instrPc_d = instrPc_q;
    case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_REQ;
        if (redirect) pc_d = redirectPc;
      end
      FETCH_REQ: begin
        if (redirect) pc_d = redirectPc;
        if (imem.imem_ready_i) state_d = redirect ? FETCH_DROP : FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (redirect) begin
          pc_d    = redirectPc;
          state_d = imem.imem_rvalid_i ? FETCH_REQ : FETCH_DROP;
        end else if (imem.imem_rvalid_i) begin
          instr_d   = imem.imem_rdata_i;
          instrPc_d = pc_q;
          state_d   = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (redirect) begin
          pc_d    = redirectPc;
          state_d = FETCH_REQ;
        end else if (instr_ready_i) begin
          pc_d    = pc_q + 32'(INSTR_BYTES);
          state_d = FETCH_REQ;
        end
      end
      FETCH_DROP: begin
        if (redirect) pc_d = redirectPc;
        if (imem.imem_rvalid_i) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_IDLE;
    endcase
`ifdef YARP_FETCH_MISALIGN_EN
    if (misalign_d && (state_d == FETCH_REQ)) state_d = FETCH_IDLE;
`endif
  end

  // State, PC, held instruction and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      instrPc_q <= 32'h0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instrPc_q <= instrPc_d;
      req_q     <= (state_d == FETCH_REQ);
      valid_q   <= (state_d == FETCH_HOLD);
    end
  end

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = pc_q;
  assign instr_valid_o    = valid_q;
  assign instr_o          = instr_q;
  assign instr_pc_o       = instrPc_q;

endmodule

// File: doc/yarp_fetch_ctrl.md
Name: yarp_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the yarp core. Owns the program counter and drives one outstanding request at a time to instruction memory.
- Holds the returned instruction until decode accepts it.
- Applies redirects coming from the branch-resolution logic (`branch_taken`) and from jumps.
- Discards any in-flight or held fetch made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address
- imem_ready_i  in  1  memory accepts request this cycle
- imem_rvalid_i  in  1  read data valid (one per accepted request, ≥1 cycle after accept)
- imem_rdata_i  in  32  read data
- instr_valid_o  out  1  held instruction valid to decode
- instr_o  out  32  held instruction
- instr_pc_o  out  32  PC of held instruction
- instr_ready_i  in  1  decode consumes instruction
- branch_taken_i  in  1  resolved conditional branch taken
- jump_i  in  1  unconditional jump (JAL/JALR)
- redirect_pc_i  in  32  target PC, valid when branch_taken_i|jump_i
- misalign_o  out  1  misaligned-redirect flag (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0, misalign_o=0.
- Derived signals:
  - redirect = branch_taken_i | jump_i. Sampled every cycle, priority over all other events.
  - imem_addr_o = pc.
  - imem_req_o = 1 only in REQ.
  - instr_valid_o = 1 only in HOLD.
- FSM states: IDLE, REQ, WAIT, HOLD, DROP.
- IDLE: → REQ the cycle after reset deasserts. A redirect in IDLE sets pc=target.
- REQ:
  - imem_ready_i=1 → WAIT.
  - With redirect and no ready: pc=target, stay REQ. imem_addr_o changes next cycle; this is the only case where the address changes while req is held.
  - Redirect with ready in the same cycle: old address was accepted → pc=target, go DROP.
- WAIT:
  - imem_rvalid_i → capture instr_o=imem_rdata_i, instr_pc_o=pc, → HOLD.
  - Redirect without rvalid: pc=target → DROP.
  - Redirect with rvalid in the same cycle: data discarded, pc=target → REQ.
- HOLD:
  - instr_ready_i=1 → pc=pc+4 (mod 2^32, wraps 0xFFFF_FFFC→0), → REQ.
  - Redirect: held instruction is flushed even if instr_ready_i=1 the same cycle. pc=target → REQ; instr_valid_o is 0 next cycle.
- DROP:
  - Waits for the stale response.
  - imem_rvalid_i → data discarded, → REQ.
  - Redirect in DROP: pc=target, stay DROP, or → REQ if rvalid arrives in the same cycle.
- Invariants:
  - Never more than one request outstanding.
  - Every accepted request consumes exactly one imem_rvalid_i.
  - A stale response never reaches instr_o.
- Throughput: min 3 cycles/instruction (REQ, WAIT, HOLD) with single-cycle memory and ready decode.
- Reset mid-operation: immediate return to reset values. An in-flight memory response after reset is not tracked; memory is reset by the same reset_n.

Optional Feature:
- Macro: YARP_FETCH_MISALIGN_EN.
- Defined:
  - A redirect with redirect_pc_i[1:0]!=0 is not applied. pc is unchanged, and the FSM still flushes/drops as for a redirect.
  - The FSM then parks in IDLE (no further requests) with misaligned state latched.
  - misalign_o=1, sticky until reset.
- Undefined: redirect_pc_i[1:0] forced to 2'b00 when loaded into pc; misalign_o tied 0.

Decomposition:
- yarp_pkg: typedef enum logic [2:0] fetch_state_e {FETCH_IDLE, FETCH_REQ, FETCH_WAIT, FETCH_HOLD, FETCH_DROP}; localparam INSTR_BYTES=4.
- No sub-module; single flat module.

Test Plan:
- Reset release, memory ready=1, rvalid 1 cycle after accept, decode ready=1 → requests at 0x0, 0x4, 0x8; instr_pc_o matches; one instruction per 3 cycles.
- Decode stalls (instr_ready_i=0 for 5 cycles) with instr 0x00500093 held → instr_valid_o stays 1; instr_o/instr_pc_o stable; no new imem_req_o.
- branch_taken_i with target 0x100 while in WAIT, rvalid 2 cycles later → response dropped; next request address 0x100; instr_valid_o never asserts for the stale data.
- jump_i with target 0x200 in HOLD while instr_ready_i=1 → held instruction flushed; pc not incremented; next request address 0x200.
- Redirect to 0x40 in REQ with imem_ready_i=0, then ready → accepted address is 0x40, no DROP.
- PC wrap: RESET_PC=0xFFFF_FFFC → second fetch address 0x0000_0000.
- With YARP_FETCH_MISALIGN_EN: redirect to 0x102 → misalign_o=1, FSM IDLE, no further requests. Without the macro: fetch at 0x100.
